vram_writer: RTL and testbench
==============================

VRAM_WRITER -- requirements
Module: vram_writer

Interface
- REQ-001 Parameter ADDR_WIDTH, default `VRAM_ADDR_WIDTH, width of the VRAM address bus.
- REQ-002 Parameter FIFO_DEPTH, default 16, number of write-FIFO entries (power of two, >=2).
- REQ-003 Parameter IDLE_ADDR, default all-ones, value driven on address when no write is issued.
- REQ-004 clk  input  1  pixel clock (12.5875 MHz); one clock, all state on rising edge.
- REQ-005 rst  input  1  reset, asynchronous, active-high.
- REQ-006 cpu_wr_en  input  1  CPU write request, one entry per cycle when high.
- REQ-007 cpu_addr  input  ADDR_WIDTH  CPU target VRAM address.
- REQ-008 cpu_data  input  8  CPU write byte.
- REQ-009 cpu_full  output  1  FIFO full; a write presented now is dropped.
- REQ-010 overflow  output  1  sticky flag: at least one write dropped.
- REQ-011 ovf_clr  input  1  clears overflow.
- REQ-012 writable  input  1  video-timing window in which VRAM may be written.
- REQ-013 vram_we  output  1  qualifies data/address as a valid VRAM write this cycle.
- REQ-014 address  output  ADDR_WIDTH  VRAM address to GPU.
- REQ-015 data  output  8  VRAM byte to GPU.
- REQ-016 pending  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
- REQ-017 FIFO SHALL store {cpu_addr, cpu_data} pairs in order; pointers wrap modulo FIFO_DEPTH; occupancy from separate count register.
- REQ-018 Push accepted iff cpu_wr_en && !cpu_full; cpu_full = (pending == FIFO_DEPTH), combinational from registered count.
- REQ-019 cpu_wr_en while cpu_full: entry dropped, FIFO unchanged, overflow set next edge, even if a pop occurs in the same cycle.
- REQ-020 overflow cleared by ovf_clr; ovf_clr and a dropped write in the same cycle: overflow remains set.
- REQ-021 FSM states: IDLE, DRAIN.
- REQ-022 IDLE -> DRAIN when writable && pending != 0; DRAIN -> IDLE when !writable or pending becomes 0 after a pop.
- REQ-023 Pop occurs in any cycle where state == DRAIN && writable && pending != 0; one pop per cycle maximum.
- REQ-024 Outputs registered: popped entry appears on address/data with vram_we = 1 on the edge after the pop cycle, for exactly one cycle.
- REQ-025 Cycles without a pop: vram_we = 0, address = IDLE_ADDR, data = 0.
- REQ-026 Minimum latency cpu_wr_en -> vram_we is 3 cycles (push, FSM entry, pop).
- REQ-027 writable falling while in DRAIN: no pop that cycle; remaining entries retained for next window; no partial or duplicate writes.
- REQ-028 Simultaneous accepted push and pop: pending unchanged, both take effect.
- REQ-029 Push into empty FIFO during DRAIN window is drained in the same window.
- REQ-030 pending SHALL never exceed FIFO_DEPTH nor underflow below 0.

Reset
- REQ-031 rst high asynchronously forces: state IDLE, pointers and pending 0, overflow 0, vram_we 0, address IDLE_ADDR, data 0, cpu_full 0.
- REQ-032 Reset mid-drain discards all queued entries; no vram_we pulse until new writes are pushed after rst deasserts.
- REQ-033 First push accepted on first rising edge after rst deasserts.

Verification
- REQ-034 Single write: push addr 0x010 data 0xA5 with writable = 1 -> vram_we one cycle, address 0x010, data 0xA5, 3 cycles after push; pending returns to 0.
- REQ-035 Window gating: push 4 entries with writable = 0 -> no vram_we, pending = 4; raise writable -> 4 consecutive vram_we cycles in push order.
- REQ-036 Window cut: 8 queued, writable drops after 3 pops -> exactly 3 writes, pending = 5; next window delivers remaining 5 in order.
- REQ-037 Overflow: 17 pushes with writable = 0, depth 16 -> cpu_full after 16th, 17th dropped, overflow = 1; ovf_clr -> overflow = 0; drain yields first 16 only.
- REQ-038 Concurrent push/pop: continuous pushes during DRAIN at 1/cycle -> pending stays constant, writes in order, no loss.
- REQ-039 Async reset: assert rst mid-drain between clock edges -> outputs immediately at reset values; no vram_we after release until new push.

Source files
------------

// File: rtl/vram_writer.sv
// ----------------------------------------------------------------------------
// vram_writer
//
// Decouples CPU byte writes from the video timing. CPU writes are queued in a
// small FIFO as {address, byte} pairs. A two-state FSM drains the queue into
// VRAM, one entry per pixel clock, and only while the video timing reports
// that VRAM may be written.
//
// Ports
//   clk        pixel clock; all state changes on its rising edge
//   rst        asynchronous, active-high reset
//   cpu_wr_en  CPU write request (one entry per cycle)
//   cpu_addr   CPU target VRAM address
//   cpu_data   CPU write byte
//   cpu_full   FIFO full; a write presented now is dropped
//   overflow   sticky: at least one write has been dropped
//   ovf_clr    clears overflow (a drop in the same cycle wins)
//   writable   video-timing window in which VRAM may be written
//   vram_we    address/data carry a valid VRAM write this cycle
//   address    VRAM address (IDLE_ADDR when no write is issued)
//   data       VRAM byte (0 when no write is issued)
//   pending    current FIFO occupancy
// ----------------------------------------------------------------------------
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

module vram_writer #(
    parameter int                    ADDR_WIDTH = `VRAM_ADDR_WIDTH,
    parameter int                    FIFO_DEPTH = 16,
    parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR  = '1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_wr_en,
    input  logic [ADDR_WIDTH-1:0]         cpu_addr,
    input  logic [7:0]                    cpu_data,
    output logic                          cpu_full,
    output logic                          overflow,
    input  logic                          ovf_clr,
    input  logic                          writable,
    output logic                          vram_we,
    output logic [ADDR_WIDTH-1:0]         address,
    output logic [7:0]                    data,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ENTRY_W-1:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic                    r_overflow;
    logic                    r_vram_we;
    logic [ADDR_WIDTH-1:0]   r_address;
    logic [7:0]              r_data;

    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_drop;
    logic [CNT_W-1:0]        w_count_next;
    logic [ENTRY_W-1:0]      w_rd_entry;

    // Full is decoded from the registered count so it never depends on this
    // cycle's pop; a write that meets a full FIFO is dropped even if a slot
    // frees up on the same edge.
    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push       = cpu_wr_en && !w_full;
    assign w_drop       = cpu_wr_en && w_full;
    assign w_pop        = (r_state == S_DRAIN) && writable && (r_count != '0);
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_rd_entry   = r_mem[r_rd_ptr];

    assign cpu_full = w_full;
    assign overflow = r_overflow;
    assign vram_we  = r_vram_we;
    assign address  = r_address;
    assign data     = r_data;
    assign pending  = r_count;

    // Storage is pure data: no reset needed, validity comes from the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cpu_addr, cpu_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_vram_we  <= 1'b0;
            r_address  <= IDLE_ADDR;
            r_data     <= 8'h00;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end

            // Registered VRAM port: the popped entry is presented for exactly
            // the cycle after the pop, otherwise the bus parks at idle values.
            if (w_pop) begin
                r_vram_we <= 1'b1;
                r_address <= w_rd_entry[ENTRY_W-1:8];
                r_data    <= w_rd_entry[7:0];
            end else begin
                r_vram_we <= 1'b0;
                r_address <= IDLE_ADDR;
                r_data    <= 8'h00;
            end

            case (r_state)
                S_IDLE: begin
                    if (writable && (r_count != '0)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Leaving on an empty queue lets a later push re-enter
                    // DRAIN within the same window one cycle after it lands.
                    if (!writable || (w_count_next == '0)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_writer.sv
// ----------------------------------------------------------------------------
// tb_vram_writer
//
// Directed scenarios followed by a randomized run. A queue-based reference
// model predicts every VRAM port value, occupancy and flag each cycle.
// ----------------------------------------------------------------------------
module tb_vram_writer;

    localparam int AW    = 12;
    localparam int DEPTH = 16;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst;
    logic            cpu_wr_en;
    logic [AW-1:0]   cpu_addr;
    logic [7:0]      cpu_data;
    logic            cpu_full;
    logic            overflow;
    logic            ovf_clr;
    logic            writable;
    logic            vram_we;
    logic [AW-1:0]   address;
    logic [7:0]      data;
    logic [PW-1:0]   pending;

    vram_writer #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_wr_en (cpu_wr_en),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_full  (cpu_full),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .writable  (writable),
        .vram_we   (vram_we),
        .address   (address),
        .data      (data),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;

    // Reference model: queued entries, whether a drain is underway, the
    // sticky drop flag and the expected VRAM port values.
    logic [AW+7:0] mq[$];
    bit            m_drain;
    bit            m_ovf;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_drain = 1'b0;
        m_ovf   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '1;
        m_data  = 8'h00;
    endtask

    // What the next rising edge should do, given the inputs now applied.
    task automatic model_edge();
        int  size_before;
        bit  full;
        bit  pop;
        bit  push;
        logic [AW+7:0] e;
        if (rst) begin
            model_reset();
            return;
        end
        size_before = mq.size();
        full = (size_before == DEPTH);
        pop  = m_drain && writable && (size_before != 0);
        push = cpu_wr_en && !full;
        if (pop) begin
            e      = mq.pop_front();
            m_we   = 1'b1;
            m_addr = e[AW+7:8];
            m_data = e[7:0];
        end else begin
            m_we   = 1'b0;
            m_addr = '1;
            m_data = 8'h00;
        end
        if (push) mq.push_back({cpu_addr, cpu_data});
        if (cpu_wr_en && full) m_ovf = 1'b1;
        else if (ovf_clr)      m_ovf = 1'b0;
        if (!m_drain) m_drain = writable && (size_before != 0);
        else          m_drain = writable && !(pop && mq.size() == 0);
    endtask

    task automatic check_outputs();
        chk("vram_we",  32'(vram_we),  32'(m_we));
        chk("address",  32'(address),  32'(m_addr));
        chk("data",     32'(data),     32'(m_data));
        chk("pending",  32'(pending),  32'(mq.size()));
        chk("cpu_full", 32'(cpu_full), 32'(mq.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (vram_we === 1'b1) n_writes++;
    endtask

    // One clock: predict, let the edge happen, sample 2 time units later.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #2;
        check_outputs();
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
        cpu_wr_en = 1'b1;
        cpu_addr  = a;
        cpu_data  = d;
        cycle();
        cpu_wr_en = 1'b0;
    endtask

    initial begin
        int lat;
        int w0;
        int p_a;
        int p_b;

        rst       = 1'b1;
        cpu_wr_en = 1'b0;
        cpu_addr  = '0;
        cpu_data  = '0;
        ovf_clr   = 1'b0;
        writable  = 1'b0;
        model_reset();
        #2;
        check_outputs();
        repeat (2) cycle();
        chk("rst_addr_idle", 32'(address), 32'hFFF);
        rst = 1'b0;

        // Single write, first push right after reset release.
        writable = 1'b1;
        push(12'h010, 8'hA5);
        chk("push_first_edge", 32'(pending), 32'd1);
        lat = 1;
        while (vram_we !== 1'b1 && lat < 10) begin
            cycle();
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        chk("single_addr", 32'(address), 32'h010);
        chk("single_data", 32'(data), 32'hA5);
        cycle();
        chk("single_one_cycle", 32'(vram_we), 32'd0);
        chk("single_empty", 32'(pending), 32'd0);

        // Window gating: queue 4 while closed, then open.
        writable = 1'b0;
        for (int i = 0; i < 4; i++) push(12'h100 + 12'(i), 8'(8'h10 + i));
        w0 = n_writes;
        repeat (3) cycle();
        chk("gated_no_write", 32'(n_writes - w0), 32'd0);
        chk("gated_pending", 32'(pending), 32'd4);
        writable = 1'b1;
        repeat (6) cycle();
        chk("gated_drained", 32'(n_writes - w0), 32'd4);

        // Window cut after 3 pops out of 8.
        writable = 1'b0;
        for (int i = 0; i < 8; i++) push(12'h200 + 12'(i), 8'(8'h20 + i));
        writable = 1'b1;
        w0 = n_writes;
        repeat (4) cycle();
        writable = 1'b0;
        repeat (3) cycle();
        chk("cut_writes", 32'(n_writes - w0), 32'd3);
        chk("cut_pending", 32'(pending), 32'd5);
        writable = 1'b1;
        repeat (8) cycle();
        chk("cut_rest", 32'(n_writes - w0), 32'd8);

        // Overflow: 16 fill, 17th dropped.
        writable = 1'b0;
        for (int i = 0; i < 16; i++) push(12'h300 + 12'(i), 8'(8'h30 + i));
        chk("full_after_16", 32'(cpu_full), 32'd1);
        push(12'h3FF, 8'hEE);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_pending", 32'(pending), 32'd16);
        ovf_clr = 1'b1;
        push(12'h3FE, 8'hEF);
        chk("ovf_clr_vs_drop", 32'(overflow), 32'd1);
        cycle();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        writable = 1'b1;
        w0 = n_writes;
        repeat (20) cycle();
        chk("ovf_drain16", 32'(n_writes - w0), 32'd16);

        // Drop while a pop happens in the same cycle still sets overflow.
        writable = 1'b0;
        for (int i = 0; i < 16; i++) push(12'h400 + 12'(i), 8'(i));
        writable = 1'b1;
        cycle();
        push(12'h4FF, 8'hFF);
        chk("ovf_drop_with_pop", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        repeat (20) cycle();

        // Continuous push during drain.
        p_a = 0;
        for (int i = 0; i < 20; i++) begin
            push(12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)));
            if (i == 5) p_a = 32'(pending);
        end
        p_b = 32'(pending);
        chk("steady_pending", 32'(p_b), 32'(p_a));
        repeat (6) cycle();

        // Async reset mid-drain.
        writable = 1'b0;
        for (int i = 0; i < 6; i++) push(12'h500 + 12'(i), 8'(8'h50 + i));
        writable = 1'b1;
        repeat (3) cycle();
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("async_we", 32'(vram_we), 32'd0);
        chk("async_pending", 32'(pending), 32'd0);
        cycle();
        rst = 1'b0;
        w0 = n_writes;
        repeat (5) cycle();
        chk("no_write_after_rst", 32'(n_writes - w0), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cpu_wr_en = ($urandom_range(0, 99) < 55);
            cpu_addr  = 12'($urandom_range(0, 4095));
            cpu_data  = 8'($urandom_range(0, 255));
            writable  = ($urandom_range(0, 99) < 45);
            ovf_clr   = ($urandom_range(0, 99) < 5);
            cycle();
        end
        cpu_wr_en = 1'b0;
        ovf_clr   = 1'b0;
        writable  = 1'b1;
        repeat (20) cycle();
        chk("final_empty", 32'(pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
